trap_csr_unit: RTL and testbench

Machine-mode trap controller and CSR holder sitting behind the writeback stage. It raises interrupt requests toward the pipeline, and accepts the committed trap or `mret` event that writeback hands back. It sequences the architectural updates: `mepc`, `mcause`, `mtval`, `mstatus`, and privilege mode. It issues the final redirect. It also owns `mtvec`, `mie` and `mip`, whose values writeback uses when deciding whether a trap is taken.

---
 rtl/trap_csr_unit.sv | 179 +++++++++++++++++
 tb/tb_trap_csr_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_csr_unit.sv
// Machine-mode trap sequencer and CSR file (mstatus/mie/mip/mtvec/mepc/mcause/mtval).
// Define TRAP_VECTORED_EN to enable vectored interrupt dispatch when mtvec[0] is set.
module trap_csr_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_mret,
    input  logic            req_is_exception,
    input  logic [5:0]      req_code,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_tval,
    input  logic            ext_meip,
    input  logic            ext_mtip,
    input  logic            ext_msip,
    input  logic            csr_we,
    input  logic [11:0]     csr_waddr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [11:0]     csr_raddr,
    output logic [XLEN-1:0] csr_rdata,
    output logic [1:0]      mode,
    output logic [XLEN-1:0] mstatus,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mie,
    output logic [XLEN-1:0] mip,
    output logic            irq_pending,
    output logic [5:0]      irq_code,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [XLEN-1:0] WORD_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b01};

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            sw_write;
    logic            is_mret_q;
    logic [XLEN-1:0] mip_sample;
    logic [XLEN-1:0] enabled_irqs;
    logic [XLEN-1:0] trap_target;

    assign accept   = (state == IDLE) && req_valid;
    // A request accepted on the same cycle wins over a software write.
    assign sw_write = (state == IDLE) && csr_we && !req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_is_mret ? RESTORE : SAVE;
            SAVE:    state_next = DONE;
            RESTORE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != IDLE);
        req_ready      = (state == IDLE);
        redirect_valid = (state == DONE);
        redirect_pc    = '0;
        if (state == DONE) redirect_pc = is_mret_q ? mepc : trap_target;
    end

    always_comb begin
        mip_sample     = '0;
        mip_sample[11] = ext_meip;
        mip_sample[7]  = ext_mtip;
        mip_sample[3]  = ext_msip;
    end

    always_comb begin
        trap_target = mtvec & WORD_MASK;
`ifdef TRAP_VECTORED_EN
        if (mtvec[0] && mcause[XLEN-1])
            trap_target = (mtvec & WORD_MASK) + (XLEN'(mcause[5:0]) << 2);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= 2'd3;
            mstatus   <= '0;
            mepc      <= '0;
            mcause    <= '0;
            mtval     <= '0;
            mtvec     <= '0;
            mie       <= '0;
            mip       <= '0;
            is_mret_q <= 1'b0;
        end else begin
            mip <= mip_sample;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_mret_q <= req_is_mret;
                        if (!req_is_mret) begin
                            mepc   <= req_pc & WORD_MASK;
                            mtval  <= req_tval;
                            mcause <= {!req_is_exception, {(XLEN-7){1'b0}}, req_code};
                        end
                    end else if (sw_write) begin
                        case (csr_waddr)
                            ADDR_MSTATUS: mstatus <= csr_wdata;
                            ADDR_MIE:     mie     <= csr_wdata;
                            ADDR_MTVEC:   mtvec   <= csr_wdata & MTVEC_MASK | (csr_wdata & ~WORD_MASK & MTVEC_MASK);
                            ADDR_MEPC:    mepc    <= csr_wdata & WORD_MASK;
                            ADDR_MCAUSE:  mcause  <= csr_wdata;
                            ADDR_MTVAL:   mtval   <= csr_wdata;
                            default: ;
                        endcase
                    end
                end
                SAVE: begin
                    mstatus[7]     <= mstatus[3];
                    mstatus[3]     <= 1'b0;
                    mstatus[12:11] <= mode;
                    mode           <= 2'd3;
                end
                RESTORE: begin
                    mode           <= mstatus[12:11];
                    mstatus[3]     <= mstatus[7];
                    mstatus[7]     <= 1'b1;
                    mstatus[12:11] <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        enabled_irqs = mip & mie;
        irq_pending  = ((mode == 2'd0) || mstatus[3]) && (|enabled_irqs);
        irq_code     = 6'd0;
        if (irq_pending) begin
            if (enabled_irqs[11])     irq_code = 6'd11;
            else if (enabled_irqs[3]) irq_code = 6'd3;
            else if (enabled_irqs[7]) irq_code = 6'd7;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            ADDR_MSTATUS: csr_rdata = mstatus;
            ADDR_MIE:     csr_rdata = mie;
            ADDR_MTVEC:   csr_rdata = mtvec;
            ADDR_MEPC:    csr_rdata = mepc;
            ADDR_MCAUSE:  csr_rdata = mcause;
            ADDR_MTVAL:   csr_rdata = mtval;
            ADDR_MIP:     csr_rdata = mip;
            default:      csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_trap_csr_unit.sv
// Self-checking bench for trap_csr_unit: directed test-plan steps then random traffic
// checked against a transaction-level CSR model.
module tb_trap_csr_unit;

    localparam int XLEN = 64;
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [11:0] A_MIP     = 12'h344;
    localparam logic [11:0] A_UNMAP   = 12'h7c0;

    logic            clk, rst;
    logic            req_valid, req_ready, req_is_mret, req_is_exception;
    logic [5:0]      req_code;
    logic [XLEN-1:0] req_pc, req_tval;
    logic            ext_meip, ext_mtip, ext_msip;
    logic            csr_we;
    logic [11:0]     csr_waddr, csr_raddr;
    logic [XLEN-1:0] csr_wdata, csr_rdata;
    logic [1:0]      mode;
    logic [XLEN-1:0] mstatus, mepc, mcause, mtval, mtvec, mie, mip;
    logic            irq_pending;
    logic [5:0]      irq_code;
    logic            busy, redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    int checks   = 0;
    int failures = 0;
    int rd_idx   = 0;

    logic [63:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_mip;
    logic [1:0]  m_mode;

    trap_csr_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_mret(req_is_mret),
        .req_is_exception(req_is_exception), .req_code(req_code),
        .req_pc(req_pc), .req_tval(req_tval),
        .ext_meip(ext_meip), .ext_mtip(ext_mtip), .ext_msip(ext_msip),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .mode(mode), .mstatus(mstatus), .mepc(mepc), .mcause(mcause),
        .mtval(mtval), .mtvec(mtvec), .mie(mie), .mip(mip),
        .irq_pending(irq_pending), .irq_code(irq_code), .busy(busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock; the model's mip captures the interrupt lines at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) m_mip = 64'd0;
        else     m_mip = 64'(ext_meip) * 2048 + 64'(ext_mtip) * 128 + 64'(ext_msip) * 8;
        #1;
    endtask

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_mip = 0; m_mode = 2'd3;
    endtask

    function automatic logic [63:0] model_read(input logic [11:0] a);
        case (a)
            A_MSTATUS: return m_mstatus;
            A_MIE:     return m_mie;
            A_MTVEC:   return m_mtvec;
            A_MEPC:    return m_mepc;
            A_MCAUSE:  return m_mcause;
            A_MTVAL:   return m_mtval;
            A_MIP:     return m_mip;
            default:   return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] model_target(input logic is_mret);
        logic [63:0] base;
        if (is_mret) return m_mepc;
        base = m_mtvec - (m_mtvec % 4);
`ifdef TRAP_VECTORED_EN
        if (m_mtvec[0] && m_mcause[63]) base = base + 4 * (m_mcause % 64);
`endif
        return base;
    endfunction

    task automatic check_irq();
        logic [63:0] en;
        logic        pend;
        int          prio [3];
        int          code;
        prio = '{11, 3, 7};
        en   = m_mip & m_mie;
        pend = ((m_mode == 2'd0) || m_mstatus[3]) && (en != 0);
        code = 0;
        if (pend) begin
            for (int i = 2; i >= 0; i--) if (en[prio[i]]) code = prio[i];
        end
        check_output("irq_pending", 64'(irq_pending), 64'(pend));
        check_output("irq_code", 64'(irq_code), 64'(code));
    endtask

    task automatic check_all();
        logic [11:0] addrs [8];
        addrs = '{A_MSTATUS, A_MIE, A_MTVEC, A_MEPC, A_MCAUSE, A_MTVAL, A_MIP, A_UNMAP};
        check_output("mstatus", mstatus, m_mstatus);
        check_output("mie", mie, m_mie);
        check_output("mtvec", mtvec, m_mtvec);
        check_output("mepc", mepc, m_mepc);
        check_output("mcause", mcause, m_mcause);
        check_output("mtval", mtval, m_mtval);
        check_output("mip", mip, m_mip);
        check_output("mode", 64'(mode), 64'(m_mode));
        check_output("idle_busy", 64'(busy), 64'd0);
        check_output("idle_ready", 64'(req_ready), 64'd1);
        check_output("idle_redirect", 64'(redirect_valid), 64'd0);
        check_irq();
        csr_raddr = addrs[rd_idx % 8];
        rd_idx++;
        #1;
        check_output("csr_rdata", csr_rdata, model_read(csr_raddr));
    endtask

    task automatic apply_csr_write(input logic [11:0] addr, input logic [63:0] data);
        csr_we = 1'b1; csr_waddr = addr; csr_wdata = data;
        tick();
        csr_we = 1'b0;
        case (addr)
            A_MSTATUS: m_mstatus = data;
            A_MIE:     m_mie     = data;
            A_MTVEC:   m_mtvec   = {data[63:2], 1'b0, data[0]};
            A_MEPC:    m_mepc    = data - (data % 4);
            A_MCAUSE:  m_mcause  = data;
            A_MTVAL:   m_mtval   = data;
            default: ;
        endcase
        check_all();
    endtask

    // One full trap or mret transaction; returns the redirect_pc seen in DONE.
    task automatic apply_stimulus(input logic is_mret, input logic is_exc, input logic [5:0] code,
                                  input logic [63:0] pc, input logic [63:0] tval,
                                  input logic collide, output logic [63:0] seen_pc);
        logic [1:0] old_mode;
        req_valid = 1'b1; req_is_mret = is_mret; req_is_exception = is_exc;
        req_code = code; req_pc = pc; req_tval = tval;
        if (collide) begin
            csr_we = 1'b1; csr_waddr = A_MTVEC; csr_wdata = {$urandom, $urandom};
        end
        tick();
        req_valid = 1'b0; csr_we = 1'b0;
        if (!is_mret) begin
            m_mepc   = pc - (pc % 4);
            m_mtval  = tval;
            m_mcause = (is_exc ? 64'd0 : 64'h8000_0000_0000_0000) + 64'(code);
        end
        check_output("seq1_busy", 64'(busy), 64'd1);
        check_output("seq1_ready", 64'(req_ready), 64'd0);
        check_output("seq1_redirect", 64'(redirect_valid), 64'd0);
        check_output("seq1_mepc", mepc, m_mepc);
        csr_we = 1'b1; csr_waddr = A_MTVAL; csr_wdata = {$urandom, $urandom};
        tick();
        csr_we = 1'b0;
        old_mode = m_mode;
        if (is_mret) begin
            m_mode        = m_mstatus[12:11];
            m_mstatus[3]  = m_mstatus[7];
            m_mstatus[7]  = 1'b1;
            m_mstatus[12:11] = 2'd0;
        end else begin
            m_mstatus[7]  = m_mstatus[3];
            m_mstatus[3]  = 1'b0;
            m_mstatus[12:11] = old_mode;
            m_mode        = 2'd3;
        end
        seen_pc = redirect_pc;
        check_output("done_redirect_valid", 64'(redirect_valid), 64'd1);
        check_output("done_redirect_pc", redirect_pc, model_target(is_mret));
        check_output("done_busy", 64'(busy), 64'd1);
        tick();
        check_all();
    endtask

    initial begin
        logic [63:0] seen;
        rst = 1'b1; req_valid = 0; req_is_mret = 0; req_is_exception = 0; req_code = 0;
        req_pc = 0; req_tval = 0; ext_meip = 0; ext_mtip = 0; ext_msip = 0;
        csr_we = 0; csr_waddr = 0; csr_wdata = 0; csr_raddr = 0;
        model_reset();
        #2;
        check_output("rst_mode", 64'(mode), 64'd3);
        check_output("rst_ready", 64'(req_ready), 64'd1);
        tick(); tick();
        rst = 1'b0;
        check_all();

        // Exception trap with MIE set
        apply_csr_write(A_MTVEC, 64'h8000_0100);
        apply_csr_write(A_MSTATUS, 64'h8);
        apply_stimulus(1'b0, 1'b1, 6'd2, 64'h8000_0044, 64'hdead, 1'b0, seen);
        check_output("t2_redirect", seen, 64'h8000_0100);
        check_output("t2_mepc", mepc, 64'h8000_0044);
        check_output("t2_mcause", mcause, 64'd2);
        check_output("t2_mtval", mtval, 64'hdead);
        check_output("t2_mstatus", mstatus, 64'h1880);
        check_output("t2_mode", 64'(mode), 64'd3);

        // mret back to U-mode
        apply_csr_write(A_MSTATUS, 64'h80);
        apply_csr_write(A_MEPC, 64'h8000_0200);
        apply_stimulus(1'b1, 1'b0, 6'd0, 64'd0, 64'd0, 1'b0, seen);
        check_output("t3_redirect", seen, 64'h8000_0200);
        check_output("t3_mode", 64'(mode), 64'd0);
        check_output("t3_mstatus", mstatus, 64'h88);

        // Interrupt priority
        apply_csr_write(A_MIE, 64'h888);
        ext_mtip = 1'b1; ext_meip = 1'b1;
        tick();
        check_all();
        check_output("t4_pending", 64'(irq_pending), 64'd1);
        check_output("t4_code_meip", 64'(irq_code), 64'd11);
        ext_meip = 1'b0;
        tick();
        check_all();
        check_output("t4_code_mtip", 64'(irq_code), 64'd7);
        ext_mtip = 1'b0;
        tick();
        check_all();

        // Software write colliding with accept is dropped
        apply_stimulus(1'b0, 1'b1, 6'd5, 64'h1234_5678, 64'h55, 1'b1, seen);
        check_output("t5_mtvec_kept", mtvec, 64'h8000_0100);

        // Reset during SAVE
        req_valid = 1'b1; req_is_mret = 1'b0; req_is_exception = 1'b1;
        req_code = 6'd1; req_pc = 64'h4000; req_tval = 64'h1;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_output("t6_rst_busy", 64'(busy), 64'd0);
        check_output("t6_rst_mepc", mepc, 64'd0);
        check_output("t6_rst_mode", 64'(mode), 64'd3);
        tick();
        check_output("t6_no_redirect_a", 64'(redirect_valid), 64'd0);
        rst = 1'b0;
        tick();
        check_output("t6_no_redirect_b", 64'(redirect_valid), 64'd0);
        tick();
        check_all();

        // Vectored interrupt dispatch
        apply_csr_write(A_MTVEC, 64'h1001);
        apply_stimulus(1'b0, 1'b0, 6'd7, 64'h2000, 64'd0, 1'b0, seen);
`ifdef TRAP_VECTORED_EN
        check_output("t7_vector", seen, 64'h101c);
`else
        check_output("t7_vector", seen, 64'h1000);
`endif

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            int op;
            logic [11:0] waddrs [8];
            waddrs = '{A_MSTATUS, A_MIE, A_MTVEC, A_MEPC, A_MCAUSE, A_MTVAL, A_MIP, A_UNMAP};
            op = int'($urandom_range(0, 4));
            case (op)
                0, 1: apply_csr_write(waddrs[$urandom_range(0, 7)], {$urandom, $urandom});
                2: begin
                    ext_meip = 1'($urandom); ext_mtip = 1'($urandom); ext_msip = 1'($urandom);
                    tick();
                    check_all();
                end
                3: apply_stimulus(1'b0, 1'($urandom), 6'($urandom), {$urandom, $urandom},
                                  {$urandom, $urandom}, 1'($urandom), seen);
                default: apply_stimulus(1'b1, 1'b0, 6'd0, 64'd0, 64'd0, 1'($urandom), seen);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
